// File: rtl/backing_mem_ctrl_pkg.sv
// Shared types and constants for the backing memory stage below the cache controller.
package mem_pkg;

    typedef enum logic [1:0] {MEM_IDLE, MEM_BUSY, MEM_DONE} mem_state_t;

    localparam logic MRW_READ  = 1'b0;
    localparam logic MRW_WRITE = 1'b1;

    // The latency counter is fixed at 8 bits, which bounds WAIT_CYCLES to 1..255.
    localparam int CTR_W = 8;

endpackage

// File: rtl/backing_mem_ctrl_if.sv
// Request/response bus between the cache controller (master) and the backing memory (slave).
interface backing_mem_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              MStrobe;
    logic              MRW;
    logic [ADDR_W-1:0] MAddr;
    logic [DATA_W-1:0] MDataIn;
    logic [DATA_W-1:0] MDataOut;
    logic              MReady;
    logic              MBusy;
    logic              ProtErr;

    modport master (
        output MStrobe, MRW, MAddr, MDataIn,
        input  MDataOut, MReady, MBusy, ProtErr
    );

    modport slave (
        input  MStrobe, MRW, MAddr, MDataIn,
        output MDataOut, MReady, MBusy, ProtErr
    );
endinterface

// File: rtl/mem_latency_ctr.sv
// Loadable down-counter that times the memory wait states; expire flags the final busy cycle.
module mem_latency_ctr
    import mem_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CTR_W-1:0] load_value,
    output logic             expire
);

    logic [CTR_W-1:0] value_reg;

    // Saturates at zero so an idle counter never wraps into a false expire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_reg <= '0;
        end else if (load) begin
            value_reg <= load_value;
        end else if (value_reg != '0) begin
            value_reg <= value_reg - 1'b1;
        end
    end

    assign expire = (value_reg == CTR_W'(1));

endmodule

// File: rtl/backing_mem_ctrl.sv
// Word-addressed main memory with a fixed wait-state latency, one request in flight at a time.
// MReady and read data are registered out of the DONE cycle, so nothing combinational reaches the outputs.
module backing_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 10,
    parameter int WAIT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    backing_mem_ctrl_if.slave  bus
);

    localparam int MEM_WORDS = 2 ** IDX_W;

    if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 255)) begin : g_bad_wait
        $error("backing_mem_ctrl: WAIT_CYCLES=%0d outside 1..255", WAIT_CYCLES);
    end

    // Upper address bits alias onto the same word; they are intentionally dropped.
    if (ADDR_W > IDX_W) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.MAddr[ADDR_W-1:IDX_W];
    end

    mem_state_t        state_reg;
    mem_state_t        state_next;
    logic              ctr_load;
    logic              ctr_expire;

    logic              req_rw_reg;
    logic [IDX_W-1:0]  req_idx_reg;
    logic [DATA_W-1:0] req_data_reg;

    logic              ready_reg;
    logic              prot_err_reg;
    logic [DATA_W-1:0] data_out_reg;

    logic [DATA_W-1:0] mem_array [MEM_WORDS];

    mem_latency_ctr u_latency_ctr (
        .clk        (clk),
        .reset      (reset),
        .load       (ctr_load),
        .load_value (CTR_W'(WAIT_CYCLES - 1)),
        .expire     (ctr_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= MEM_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // DONE behaves like IDLE for a new strobe, which allows back-to-back requests.
    always_comb begin
        state_next = state_reg;
        ctr_load   = 1'b0;
        case (state_reg)
            MEM_IDLE, MEM_DONE: begin
                if (bus.MStrobe) begin
                    ctr_load   = 1'b1;
                    state_next = (WAIT_CYCLES == 1) ? MEM_DONE : MEM_BUSY;
                end else begin
                    state_next = MEM_IDLE;
                end
            end
            MEM_BUSY: begin
                if (ctr_expire) begin
                    state_next = MEM_DONE;
                end
            end
            default: state_next = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_rw_reg   <= MRW_READ;
            req_idx_reg  <= '0;
            req_data_reg <= '0;
        end else if (ctr_load) begin
            req_rw_reg   <= bus.MRW;
            req_idx_reg  <= bus.MAddr[IDX_W-1:0];
            req_data_reg <= bus.MDataIn;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prot_err_reg <= 1'b0;
        end else if ((state_reg == MEM_BUSY) && bus.MStrobe) begin
            prot_err_reg <= 1'b1;
        end
    end

    // The array port is used only in DONE: one write or one read per request.
    always_ff @(posedge clk) begin
        if ((state_reg == MEM_DONE) && (req_rw_reg == MRW_WRITE)) begin
            mem_array[req_idx_reg] <= req_data_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_reg    <= 1'b0;
            data_out_reg <= '0;
        end else begin
            ready_reg <= (state_reg == MEM_DONE);
            if ((state_reg == MEM_DONE) && (req_rw_reg == MRW_READ)) begin
                data_out_reg <= mem_array[req_idx_reg];
            end
        end
    end

    assign bus.MReady   = ready_reg;
    assign bus.MBusy    = (state_reg != MEM_IDLE);
    assign bus.ProtErr  = prot_err_reg;
    assign bus.MDataOut = data_out_reg;

endmodule

// File: tb/tb_backing_mem_ctrl.sv
// Scoreboard bench: two builds (WAIT_CYCLES=4 and 1) driven by directed and random requests.
module tb_backing_mem_ctrl;
    import mem_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 10;
    localparam int NDUT   = 2;
    localparam int W0     = 4;
    localparam int W1     = 1;

    typedef struct {
        logic        rw;
        int          idx;
        logic [31:0] wdata;
        int          exp_cyc;
    } req_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        strobe [NDUT];
    logic        rw     [NDUT];
    logic [15:0] addr   [NDUT];
    logic [31:0] wdata  [NDUT];
    logic        ready  [NDUT];
    logic        busy   [NDUT];
    logic        prot   [NDUT];
    logic [31:0] dout   [NDUT];

    req_t        exp_q     [NDUT][$];
    logic [31:0] model_mem [NDUT][1024];
    bit          known     [NDUT][1024];
    bit          exp_prot  [NDUT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    backing_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
    backing_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

    assign bus0.MStrobe = strobe[0];
    assign bus0.MRW     = rw[0];
    assign bus0.MAddr   = addr[0];
    assign bus0.MDataIn = wdata[0];
    assign ready[0]     = bus0.MReady;
    assign busy[0]      = bus0.MBusy;
    assign prot[0]      = bus0.ProtErr;
    assign dout[0]      = bus0.MDataOut;

    assign bus1.MStrobe = strobe[1];
    assign bus1.MRW     = rw[1];
    assign bus1.MAddr   = addr[1];
    assign bus1.MDataIn = wdata[1];
    assign ready[1]     = bus1.MReady;
    assign busy[1]      = bus1.MBusy;
    assign prot[1]      = bus1.ProtErr;
    assign dout[1]      = bus1.MDataOut;

    backing_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W), .WAIT_CYCLES(W0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    backing_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W), .WAIT_CYCLES(W1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, d, cyc, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; the request is sampled on the next rising edge.
    task automatic issue(input int d, input logic w, input logic [15:0] a, input logic [31:0] data);
        req_t r;
        strobe[d] = 1'b1;
        rw[d]     = w;
        addr[d]   = a;
        wdata[d]  = data;
        r.rw      = w;
        r.idx     = int'(a[9:0]);
        r.wdata   = data;
        r.exp_cyc = cyc + 1 + wait_of(d);
        exp_q[d].push_back(r);
        @(negedge clk);
        strobe[d] = 1'b0;
        rw[d]     = 1'($urandom);
        addr[d]   = 16'($urandom);
        wdata[d]  = $urandom;
    endtask

    task automatic random_traffic(input int d, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = 16'($urandom) & 16'hFC0F;
            issue(d, 1'($urandom), a, $urandom);
            idle($urandom_range(wait_of(d) + 2, wait_of(d) - 1));
        end
    endtask

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_mon
        always @(posedge clk) begin : mon
            req_t r;
            #1;
            if (ready[gi]) begin
                if (exp_q[gi].size() == 0) begin
                    check("unexpected_mready", gi, 32'(ready[gi]), 32'd0);
                end else begin
                    r = exp_q[gi].pop_front();
                    check("latency", gi, cyc, r.exp_cyc);
                    if (r.rw) begin
                        model_mem[gi][r.idx] = r.wdata;
                        known[gi][r.idx]     = 1'b1;
                    end else if (known[gi][r.idx]) begin
                        check("rdata", gi, dout[gi], model_mem[gi][r.idx]);
                    end
                    check("proterr", gi, 32'(prot[gi]), 32'(exp_prot[gi]));
                    $display("dut%0d cyc %0d %s idx %03h data %08h", gi, cyc,
                             r.rw ? "WR" : "RD", r.idx, r.rw ? r.wdata : dout[gi]);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            strobe[d] = 1'b0; rw[d] = 1'b0; addr[d] = '0; wdata[d] = '0; exp_prot[d] = 1'b0;
        end
        #1 reset = 1'b0;
        idle(2);
        for (int d = 0; d < NDUT; d++) begin
            check("reset_mready", d, 32'(ready[d]), 32'd0);
            check("reset_mbusy", d, 32'(busy[d]), 32'd0);
            check("reset_proterr", d, 32'(prot[d]), 32'd0);
            check("reset_mdataout", d, dout[d], 32'd0);
        end
        reset = 1'b1;
        idle(2);

        // Write then read, same word
        issue(0, MRW_WRITE, 16'h0003, 32'hCAFEF00D); idle(W0);
        issue(0, MRW_READ, 16'h0003, 32'h0);         idle(W0);

        // Read strobed in the DONE cycle of a write to the same word
        issue(0, MRW_WRITE, 16'h0020, 32'hA5A55A5A); idle(W0 - 1);
        check("busy_in_done", 0, 32'(busy[0]), 32'd1);
        issue(0, MRW_READ, 16'h0020, 32'h0);         idle(W0);

        // Address aliasing above IDX_W
        issue(0, MRW_WRITE, 16'h0405, 32'h11111111); idle(W0);
        issue(0, MRW_READ, 16'h0005, 32'h0);         idle(W0);

        random_traffic(0, 40);

        // Strobe two cycles into a request sets the sticky error
        issue(0, MRW_READ, 16'h0003, 32'h0);
        idle(1);
        strobe[0] = 1'b1; rw[0] = MRW_WRITE; addr[0] = 16'h0003; wdata[0] = 32'hBAD0BAD0;
        exp_prot[0] = 1'b1;
        @(negedge clk);
        strobe[0] = 1'b0;
        idle(3);
        check("proterr_set", 0, 32'(prot[0]), 32'd1);
        random_traffic(0, 8);
        check("proterr_sticky", 0, 32'(prot[0]), 32'd1);

        // WAIT_CYCLES=1 build: no strobes keeps MBusy low, then back-to-back traffic
        for (int i = 0; i < 12; i++) begin
            check("idle_mbusy", 1, 32'(busy[1]), 32'd0);
            @(negedge clk);
        end
        issue(1, MRW_WRITE, 16'h0033, 32'h5EED1234);
        issue(1, MRW_READ, 16'h0033, 32'h0);
        idle(2);
        random_traffic(1, 30);
        idle(3);

        // Reset while a write is busy aborts it without touching the array
        issue(0, MRW_WRITE, 16'h0010, 32'h12345678); idle(W0);
        issue(0, MRW_WRITE, 16'h0010, 32'hDEADBEEF);
        idle(1);
        reset = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        exp_prot[0] = 1'b0;
        idle(2);
        check("abort_mbusy", 0, 32'(busy[0]), 32'd0);
        reset = 1'b1;
        idle(6);
        check("reset_clears_proterr", 0, 32'(prot[0]), 32'd0);
        issue(0, MRW_READ, 16'h0010, 32'h0);
        idle(W0 + 1);

        for (int t = 0; t < 50 && (exp_q[0].size() + exp_q[1].size()) != 0; t++) @(negedge clk);
        check("drain", 0, 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
